// File: rtl/ccm_pkg.sv
// ccm_pkg: shared sizes, beat record and FSM state for compute_cluster_mem
// Contents:
//   CCM_* localparams : default cluster dimensions
//   beat_t            : one stored beat {sparsemap, packed nonzero bytes}
//   state_e           : compute FSM states
package ccm_pkg;
    localparam int CCM_BUS_SIZE        = 8;
    localparam int CCM_WR_DAT_CYC_NUM  = 4;
    localparam int CCM_SRAM_IFM_NUM    = 16;
    localparam int CCM_SRAM_FILTER_NUM = 16;
    localparam int CCM_COMPUTE_UNIT_NUM = 2;
    localparam int CCM_OUTPUT_BUF_NUM  = 4;
    localparam int CCM_OUTPUT_BUF_SIZE = 32;

    typedef struct packed {
        logic [CCM_BUS_SIZE-1:0]   map;
        logic [CCM_BUS_SIZE*8-1:0] data;
    } beat_t;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/ccm_dot_unit.sv
// ccm_dot_unit: combinational sparse unpack and signed dot product of one beat
// Ports:
//   ifm_i  : IFM beat (sparsemap + packed nonzero bytes)
//   fil_i  : filter beat (sparsemap + packed nonzero bytes)
//   dot_o  : two's-complement sum of lane products, OUT_W bits, wrapping
module ccm_dot_unit
    import ccm_pkg::*;
#(
    parameter int OUT_W = CCM_OUTPUT_BUF_SIZE
) (
    input  beat_t              ifm_i,
    input  beat_t              fil_i,
    output logic [OUT_W-1:0]   dot_o
);
    logic signed [7:0]       a, b;
    logic signed [15:0]      p;
    logic signed [OUT_W-1:0] sum;
    int                      ci, cf;

    // Lane j's byte sits at packed position popcount(map[j-1:0]), tracked by
    // running counters. An absent lane contributes zero, so only lanes set in
    // both maps add to the sum.
    always_comb begin
        sum = '0;
        ci  = 0;
        cf  = 0;
        a   = '0;
        b   = '0;
        p   = '0;
        for (int j = 0; j < CCM_BUS_SIZE; j++) begin
            a   = ifm_i.map[j] ? ifm_i.data[ci*8 +: 8] : '0;
            b   = fil_i.map[j] ? fil_i.data[cf*8 +: 8] : '0;
            ci  = ci + int'(ifm_i.map[j]);
            cf  = cf + int'(fil_i.map[j]);
            p   = a * b;
            sum = sum + OUT_W'(p);
        end
    end

    assign dot_o = sum;
endmodule

// File: rtl/compute_cluster_mem.sv
// compute_cluster_mem: sparse IFM/filter store with ping-pong chunk buffers and per-unit MAC
// Ports:
//   clk_i, rst_i (sync, active-low)
//   ifm_/fil_sram_wr_*      : SRAM beat writes at [chunk_count][dat_count]
//   ifm_/fil_chunk_wr_*     : copy SRAM[rd_count][wr_count] into buffer half wr_sel
//   fil_chunk_cu_wr_sel_i   : units receiving a filter copy (multi-hot)
//   ifm_/fil_chunk_rd_sel_i : buffer halves used by compute
//   run_valid_i, total_chunk_start_i, rd_fil_sparsemap_last_i, acc_buf_sel_i : run control
//   total_chunk_end_o       : one-cycle done pulse
//   com_unit_out_buf_sel_i, out_buf_dat_o : combinational accumulator readout
// Option: CCM_ZERO_SKIP_EN visits only beats where some unit has overlapping maps.
module compute_cluster_mem
    import ccm_pkg::*;
#(
    parameter int BUS_SIZE         = CCM_BUS_SIZE,
    parameter int WR_DAT_CYC_NUM   = CCM_WR_DAT_CYC_NUM,
    parameter int SRAM_IFM_NUM     = CCM_SRAM_IFM_NUM,
    parameter int SRAM_FILTER_NUM  = CCM_SRAM_FILTER_NUM,
    parameter int COMPUTE_UNIT_NUM = CCM_COMPUTE_UNIT_NUM,
    parameter int OUTPUT_BUF_NUM   = CCM_OUTPUT_BUF_NUM,
    parameter int OUTPUT_BUF_SIZE  = CCM_OUTPUT_BUF_SIZE,
    localparam int CW = $clog2(WR_DAT_CYC_NUM),
    localparam int IW = $clog2(SRAM_IFM_NUM),
    localparam int FW = $clog2(SRAM_FILTER_NUM),
    localparam int UW = $clog2(COMPUTE_UNIT_NUM),
    localparam int AW = $clog2(OUTPUT_BUF_NUM)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ifm_sram_wr_valid_i,
    input  logic [BUS_SIZE-1:0]         ifm_sram_wr_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]       ifm_sram_wr_nonzero_data_i,
    input  logic [CW-1:0]               ifm_sram_wr_dat_count_i,
    input  logic [IW-1:0]               ifm_sram_wr_chunk_count_i,
    input  logic                        fil_sram_wr_valid_i,
    input  logic [BUS_SIZE-1:0]         fil_sram_wr_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]       fil_sram_wr_nonzero_data_i,
    input  logic [CW-1:0]               fil_sram_wr_dat_count_i,
    input  logic [FW-1:0]               fil_sram_wr_chunk_count_i,
    input  logic                        ifm_chunk_wr_valid_i,
    input  logic [CW-1:0]               ifm_chunk_wr_count_i,
    input  logic                        ifm_chunk_wr_sel_i,
    input  logic                        ifm_chunk_rd_sel_i,
    input  logic [IW-1:0]               ifm_sram_rd_count_i,
    input  logic                        fil_chunk_wr_valid_i,
    input  logic [CW-1:0]               fil_chunk_wr_count_i,
    input  logic                        fil_chunk_wr_sel_i,
    input  logic                        fil_chunk_rd_sel_i,
    input  logic [FW-1:0]               fil_sram_rd_count_i,
    input  logic [COMPUTE_UNIT_NUM-1:0] fil_chunk_cu_wr_sel_i,
    input  logic                        run_valid_i,
    input  logic                        total_chunk_start_i,
    input  logic [CW-1:0]               rd_fil_sparsemap_last_i,
    input  logic [AW-1:0]               acc_buf_sel_i,
    output logic                        total_chunk_end_o,
    input  logic [UW-1:0]               com_unit_out_buf_sel_i,
    output logic [OUTPUT_BUF_SIZE-1:0]  out_buf_dat_o
);
    beat_t ifm_sram_q [SRAM_IFM_NUM][WR_DAT_CYC_NUM];
    beat_t fil_sram_q [SRAM_FILTER_NUM][WR_DAT_CYC_NUM];
    beat_t ifm_buf_q  [2][WR_DAT_CYC_NUM];
    beat_t fil_buf_q  [COMPUTE_UNIT_NUM][2][WR_DAT_CYC_NUM];
    logic [OUTPUT_BUF_SIZE-1:0] acc_q [COMPUTE_UNIT_NUM][OUTPUT_BUF_NUM];
    logic [OUTPUT_BUF_SIZE-1:0] dot   [COMPUTE_UNIT_NUM];

    state_e        state_q;
    logic [CW-1:0] beat_q, last_q;
    logic [AW-1:0] sel_q;
    logic          end_q;
    logic [CW-1:0] first_d, beat_d;
    logic          first_ok, more_d;

    // SRAMs; nonblocking updates mean a same-edge copy sees the old entry
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int c = 0; c < SRAM_IFM_NUM; c++)
                for (int k = 0; k < WR_DAT_CYC_NUM; k++)
                    ifm_sram_q[c][k] <= '0;
            for (int c = 0; c < SRAM_FILTER_NUM; c++)
                for (int k = 0; k < WR_DAT_CYC_NUM; k++)
                    fil_sram_q[c][k] <= '0;
        end else begin
            if (ifm_sram_wr_valid_i)
                ifm_sram_q[ifm_sram_wr_chunk_count_i][ifm_sram_wr_dat_count_i] <=
                    '{map: ifm_sram_wr_sparsemap_i, data: ifm_sram_wr_nonzero_data_i};
            if (fil_sram_wr_valid_i)
                fil_sram_q[fil_sram_wr_chunk_count_i][fil_sram_wr_dat_count_i] <=
                    '{map: fil_sram_wr_sparsemap_i, data: fil_sram_wr_nonzero_data_i};
        end
    end

    // Ping-pong chunk buffers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int h = 0; h < 2; h++)
                for (int k = 0; k < WR_DAT_CYC_NUM; k++) begin
                    ifm_buf_q[h][k] <= '0;
                    for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
                        fil_buf_q[u][h][k] <= '0;
                end
        end else begin
            if (ifm_chunk_wr_valid_i)
                ifm_buf_q[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i] <=
                    ifm_sram_q[ifm_sram_rd_count_i][ifm_chunk_wr_count_i];
            for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
                if (fil_chunk_wr_valid_i && fil_chunk_cu_wr_sel_i[u])
                    fil_buf_q[u][fil_chunk_wr_sel_i][fil_chunk_wr_count_i] <=
                        fil_sram_q[fil_sram_rd_count_i][fil_chunk_wr_count_i];
        end
    end

    for (genvar g = 0; g < COMPUTE_UNIT_NUM; g++) begin : g_cu
        ccm_dot_unit #(.OUT_W(OUTPUT_BUF_SIZE)) u_dot (
            .ifm_i (ifm_buf_q[ifm_chunk_rd_sel_i][beat_q]),
            .fil_i (fil_buf_q[g][fil_chunk_rd_sel_i][beat_q]),
            .dot_o (dot[g])
        );
    end

`ifdef CCM_ZERO_SKIP_EN
    logic [WR_DAT_CYC_NUM-1:0] act;

    // A beat is worth a cycle when any unit has a lane set in both maps
    always_comb begin
        act = '0;
        for (int k = 0; k < WR_DAT_CYC_NUM; k++)
            for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
                act[k] = act[k] |
                    (|(ifm_buf_q[ifm_chunk_rd_sel_i][k].map & fil_buf_q[u][fil_chunk_rd_sel_i][k].map));
    end

    // Lowest-index priority encoders: first beat at start, next beat while running
    always_comb begin
        first_d  = '0;
        first_ok = 1'b0;
        beat_d   = '0;
        more_d   = 1'b0;
        for (int k = WR_DAT_CYC_NUM - 1; k >= 0; k--) begin
            if (act[k] && CW'(k) <= rd_fil_sparsemap_last_i) begin
                first_d  = CW'(k);
                first_ok = 1'b1;
            end
            if (act[k] && CW'(k) > beat_q && CW'(k) <= last_q) begin
                beat_d = CW'(k);
                more_d = 1'b1;
            end
        end
    end
`else
    assign first_d  = '0;
    assign first_ok = 1'b1;
    assign beat_d   = beat_q + CW'(1);
    assign more_d   = beat_q != last_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            last_q  <= '0;
            sel_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (total_chunk_start_i && run_valid_i) begin
                    sel_q  <= acc_buf_sel_i;
                    last_q <= rd_fil_sparsemap_last_i;
                    beat_q <= first_d;
                    if (first_ok)
                        state_q <= ST_RUN;
                    else
                        end_q <= 1'b1;
                end
            end else if (!run_valid_i) begin
                state_q <= ST_IDLE;
            end else if (more_d) begin
                beat_q <= beat_d;
            end else begin
                state_q <= ST_IDLE;
                end_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
                for (int k = 0; k < OUTPUT_BUF_NUM; k++)
                    acc_q[u][k] <= '0;
        end else if (state_q == ST_RUN && run_valid_i) begin
            for (int u = 0; u < COMPUTE_UNIT_NUM; u++)
                acc_q[u][sel_q] <= acc_q[u][sel_q] + dot[u];
        end
    end

    assign total_chunk_end_o = end_q;
    assign out_buf_dat_o     = acc_q[com_unit_out_buf_sel_i][acc_buf_sel_i];
endmodule

// File: tb/tb_compute_cluster_mem.sv
// tb_compute_cluster_mem: directed self-checking bench for compute_cluster_mem
module tb_compute_cluster_mem;
`ifdef CCM_ZERO_SKIP_EN
    localparam int LAT_SPARSE = 0;
`else
    localparam int LAT_SPARSE = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifm_sv = 0, fil_sv = 0;
    logic [7:0]  ifm_map = 0, fil_map = 0;
    logic [63:0] ifm_dat = 0, fil_dat = 0;
    logic [1:0]  ifm_dc = 0, fil_dc = 0;
    logic [3:0]  ifm_cc = 0, fil_cc = 0;
    logic        ifm_cv = 0, fil_cv = 0;
    logic [1:0]  ifm_cn = 0, fil_cn = 0;
    logic        ifm_ws = 0, fil_ws = 0, ifm_rs = 0, fil_rs = 0;
    logic [3:0]  ifm_rc = 0, fil_rc = 0;
    logic [1:0]  cu_ws = 0;
    logic        run_valid = 1, start = 0;
    logic [1:0]  last = 0, acc_sel = 0;
    logic        com_sel = 0;
    logic        end_o;
    logic [31:0] out;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    compute_cluster_mem dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .ifm_sram_wr_valid_i        (ifm_sv),
        .ifm_sram_wr_sparsemap_i    (ifm_map),
        .ifm_sram_wr_nonzero_data_i (ifm_dat),
        .ifm_sram_wr_dat_count_i    (ifm_dc),
        .ifm_sram_wr_chunk_count_i  (ifm_cc),
        .fil_sram_wr_valid_i        (fil_sv),
        .fil_sram_wr_sparsemap_i    (fil_map),
        .fil_sram_wr_nonzero_data_i (fil_dat),
        .fil_sram_wr_dat_count_i    (fil_dc),
        .fil_sram_wr_chunk_count_i  (fil_cc),
        .ifm_chunk_wr_valid_i       (ifm_cv),
        .ifm_chunk_wr_count_i       (ifm_cn),
        .ifm_chunk_wr_sel_i         (ifm_ws),
        .ifm_chunk_rd_sel_i         (ifm_rs),
        .ifm_sram_rd_count_i        (ifm_rc),
        .fil_chunk_wr_valid_i       (fil_cv),
        .fil_chunk_wr_count_i       (fil_cn),
        .fil_chunk_wr_sel_i         (fil_ws),
        .fil_chunk_rd_sel_i         (fil_rs),
        .fil_sram_rd_count_i        (fil_rc),
        .fil_chunk_cu_wr_sel_i      (cu_ws),
        .run_valid_i                (run_valid),
        .total_chunk_start_i        (start),
        .rd_fil_sparsemap_last_i    (last),
        .acc_buf_sel_i              (acc_sel),
        .total_chunk_end_o          (end_o),
        .com_unit_out_buf_sel_i     (com_sel),
        .out_buf_dat_o              (out)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic u, input logic [1:0] s, input logic [31:0] exp, input string tag);
        com_sel = u;
        acc_sel = s;
        #1;
        chk(tag, out, exp);
    endtask

    task automatic wr_ifm(input logic [3:0] c, input logic [7:0] m, input logic [63:0] d, input int nb);
        for (int i = 0; i < nb; i++) begin
            ifm_sv = 1; ifm_cc = c; ifm_dc = 2'(i); ifm_map = m; ifm_dat = d;
            tick();
        end
        ifm_sv = 0;
    endtask

    task automatic wr_fil(input logic [3:0] c, input logic [7:0] m, input logic [63:0] d, input int nb);
        for (int i = 0; i < nb; i++) begin
            fil_sv = 1; fil_cc = c; fil_dc = 2'(i); fil_map = m; fil_dat = d;
            tick();
        end
        fil_sv = 0;
    endtask

    task automatic cp_ifm(input logic [3:0] c, input logic h, input int nb);
        for (int i = 0; i < nb; i++) begin
            ifm_cv = 1; ifm_rc = c; ifm_ws = h; ifm_cn = 2'(i);
            tick();
        end
        ifm_cv = 0;
    endtask

    task automatic cp_fil(input logic [3:0] c, input logic h, input logic [1:0] cu, input int nb);
        for (int i = 0; i < nb; i++) begin
            fil_cv = 1; fil_rc = c; fil_ws = h; fil_cn = 2'(i); cu_ws = cu;
            tick();
        end
        fil_cv = 0;
    endtask

    // Start at the next edge, count edges until end_o is seen, then check it drops
    task automatic run_wait(input logic [1:0] s, input logic [1:0] l, input int exp, input string tag);
        int c;
        acc_sel = s; last = l; start = 1;
        tick();
        start = 0;
        c = 0;
        while (!end_o && c < 20) begin
            tick();
            c++;
        end
        chk({tag, "_lat"}, 32'(c), 32'(exp));
        tick();
        chk({tag, "_pulse"}, {31'd0, end_o}, 32'd0);
    endtask

    initial begin
        int c;
        repeat (3) tick();
        chk("rst_end", {31'd0, end_o}, 32'd0);
        rst = 1;
        tick();
        rd(1, 3, 32'd0, "rst_acc");

        // dense: 4 beats x 8 lanes x 1*2
        wr_ifm(0, 8'hFF, 64'h0101010101010101, 4);
        wr_fil(0, 8'hFF, 64'h0202020202020202, 4);
        cp_ifm(0, 0, 4);
        cp_fil(0, 0, 2'b11, 4);
        run_wait(0, 3, 4, "dense");
        rd(0, 0, 32'd64, "dense_u0");
        rd(1, 0, 32'd64, "dense_u1");

        // sparse: maps never overlap
        wr_ifm(1, 8'h0F, 64'h01010101, 4);
        wr_fil(1, 8'hF0, 64'h01010101, 4);
        cp_ifm(1, 0, 4);
        cp_fil(1, 0, 2'b11, 4);
        run_wait(1, 3, LAT_SPARSE, "sparse");
        rd(0, 1, 32'd0, "sparse_u0");
        rd(1, 1, 32'd0, "sparse_u1");

        // signed single lane in half 1: -3 * 5
        wr_ifm(2, 8'h01, 64'hFD, 1);
        wr_fil(2, 8'h01, 64'h05, 1);
        cp_ifm(2, 1, 1);
        cp_fil(2, 1, 2'b11, 1);
        ifm_rs = 1; fil_rs = 1;
        run_wait(2, 0, 1, "signed");
        rd(0, 2, 32'hFFFFFFF1, "signed_u0");
        rd(1, 2, 32'hFFFFFFF1, "signed_u1");
        ifm_rs = 0; fil_rs = 0;

        // ping-pong: compute half 0 (chunk 0) while chunk 1 lands in half 1
        cp_ifm(0, 0, 4);
        cp_fil(0, 0, 2'b11, 4);
        acc_sel = 3; last = 3; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            ifm_cv = 1; ifm_ws = 1; ifm_rc = 1; ifm_cn = 2'(i);
            tick();
        end
        ifm_cv = 0;
        chk("pp_end", {31'd0, end_o}, 32'd1);
        rd(0, 3, 32'd64, "pp_u0");
        rd(1, 3, 32'd64, "pp_u1");

        // multi-unit filters; start held into RUN must be ignored
        wr_fil(3, 8'hFF, 64'h0303030303030303, 4);
        wr_fil(4, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 4);
        cp_fil(3, 0, 2'b01, 4);
        cp_fil(4, 0, 2'b10, 4);
        acc_sel = 0; last = 1; start = 1;
        tick();
        tick();
        start = 0;
        c = 1;
        while (!end_o && c < 20) begin
            tick();
            c++;
        end
        chk("multi_lat", 32'(c), 32'd2);
        rd(0, 0, 32'd112, "multi_u0");
        rd(1, 0, 32'd48, "multi_u1");

        // abort after two beats, then restart from beat 0
        acc_sel = 1; last = 3; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        run_valid = 0;
        tick();
        chk("abort_end0", {31'd0, end_o}, 32'd0);
        tick();
        chk("abort_end1", {31'd0, end_o}, 32'd0);
        run_valid = 1;
        rd(0, 1, 32'd48, "abort_u0");
        rd(1, 1, 32'hFFFFFFF0, "abort_u1");
        run_wait(1, 3, 4, "resume");
        rd(0, 1, 32'd144, "resume_u0");
        rd(1, 1, 32'hFFFFFFD0, "resume_u1");

        // reset mid-RUN: no end pulse, accumulators cleared
        acc_sel = 0; last = 3; start = 1;
        tick();
        start = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        rd(0, 0, 32'd0, "midrst_acc");
        for (int i = 0; i < 4; i++) begin
            chk("midrst_end", {31'd0, end_o}, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
